// File: rtl/inst_fetch_unit_if.sv
// Fetch-stage bus: memory instruction port, redirect request and decode handshake.
interface inst_fetch_unit_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 16
);
  logic [ADDR_W-1:0] inst_addr;
  logic [DATA_W-1:0] inst_data;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              out_valid;
  logic [DATA_W-1:0] out_instr;
  logic [ADDR_W-1:0] out_pc;
  logic              out_ready;

  // Fetch unit side
  modport master (
    output inst_addr,
    input  inst_data,
    input  redirect,
    input  redirect_pc,
    output out_valid,
    output out_instr,
    output out_pc,
    input  out_ready
  );

  // Memory / decode / controller side
  modport slave (
    input  inst_addr,
    output inst_data,
    output redirect,
    output redirect_pc,
    input  out_valid,
    input  out_instr,
    input  out_pc,
    output out_ready
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch: owns the PC, prefetches words into a small FIFO and
// hands them to decode; a redirect flushes the FIFO and reloads the PC.
module inst_fetch_unit #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned RESET_PC = 0
) (
  input  logic                clk,
  input  logic                rst,
  inst_fetch_unit_if.master   bus
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] r_pc;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [ADDR_W-1:0] r_fifo_pc    [DEPTH];
  logic [DATA_W-1:0] r_fifo_instr [DEPTH];

  logic w_valid;
  logic w_pop;
  logic w_push;

  // Handshake qualifiers; a full FIFO still fetches when the head leaves
  always_comb begin
    w_valid = (r_count != '0);
    w_pop   = w_valid & bus.out_ready & ~bus.redirect;
    w_push  = ~bus.redirect & ((r_count < CNT_W'(DEPTH)) | w_pop);
  end

  assign bus.inst_addr = r_pc;
  assign bus.out_valid = w_valid;
  assign bus.out_pc    = r_fifo_pc[r_rd_ptr];
  assign bus.out_instr = r_fifo_instr[r_rd_ptr];

  // PC, pointers and occupancy; reset beats redirect, redirect beats fetch
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc     <= ADDR_W'(RESET_PC);
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (bus.redirect) begin
      r_pc     <= bus.redirect_pc;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_pc     <= r_pc + ADDR_W'(1);
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage; contents need no reset since out_valid gates them
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_fifo_pc[r_wr_ptr]    <= r_pc;
      r_fifo_instr[r_wr_ptr] <= bus.inst_data;
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit with a queue of expected deliveries.
module tb_inst_fetch_unit;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 16;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  inst_fetch_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ifc ();

  inst_fetch_unit #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(2), .RESET_PC(0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  always #5 clk = ~clk;

  // Memory contents are a fixed function of the word address
  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return DATA_W'(32'(a) * 32'd4889 + 32'h5A3C);
  endfunction

  assign ifc.inst_data = mem_word(ifc.inst_addr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input int unsigned a);
    exp_t e;
    e.pc    = ADDR_W'(a);
    e.instr = mem_word(ADDR_W'(a));
    q.push_back(e);
  endtask

  task automatic expect_out(input string tag);
    exp_t e;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed delivery expected empty scoreboard", tag);
    end else begin
      e = q.pop_front();
      chk({tag, "_valid"}, 32'(ifc.out_valid), 32'd1);
      chk({tag, "_pc"},    32'(ifc.out_pc),    32'(e.pc));
      chk({tag, "_instr"}, 32'(ifc.out_instr), 32'(e.instr));
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ifc.redirect = 1'b0;
    cyc();
    rst = 1'b0;
    chk("rst_valid", 32'(ifc.out_valid), 32'd0);
    chk("rst_addr",  32'(ifc.inst_addr), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    ifc.redirect    = 1'b0;
    ifc.redirect_pc = '0;
    ifc.out_ready   = 1'b0;

    // 1: streaming from reset, one word per cycle
    ifc.out_ready = 1'b1;
    do_reset();
    push_exp(0); push_exp(1); push_exp(2);
    cyc(); expect_out("t1_0");
    cyc(); expect_out("t1_1");
    cyc(); expect_out("t1_2");

    // 2: stall fills the FIFO, then drains back-to-back
    ifc.out_ready = 1'b0;
    do_reset();
    repeat (5) cyc();
    chk("t2_addr_hold", 32'(ifc.inst_addr), 32'd2);
    chk("t2_head_pc",   32'(ifc.out_pc),    32'd0);
    chk("t2_head_data", 32'(ifc.out_instr), 32'(mem_word(10'd0)));
    ifc.out_ready = 1'b1;
    push_exp(0); push_exp(1); push_exp(2); push_exp(3);
    expect_out("t2_0");
    cyc(); expect_out("t2_1");
    cyc(); expect_out("t2_2");
    cyc(); expect_out("t2_3");

    // 3: redirect to 12 while FIFO holds 4 and 5
    do_reset();
    repeat (5) cyc();
    chk("t3_head4", 32'(ifc.out_pc), 32'd4);
    ifc.out_ready = 1'b0;
    cyc();
    chk("t3_held4", 32'(ifc.out_pc),    32'd4);
    chk("t3_addr6", 32'(ifc.inst_addr), 32'd6);
    ifc.redirect = 1'b1; ifc.redirect_pc = 10'd12;
    cyc();
    chk("t3_flush_valid", 32'(ifc.out_valid), 32'd0);
    chk("t3_flush_addr",  32'(ifc.inst_addr), 32'd12);
    ifc.redirect = 1'b0; ifc.out_ready = 1'b1;
    push_exp(12); push_exp(13); push_exp(14);
    cyc(); expect_out("t3_12");
    cyc(); expect_out("t3_13");
    cyc(); expect_out("t3_14");

    // 4: redirect during an accepted handshake, then 3 back-to-back redirects
    ifc.redirect = 1'b1; ifc.redirect_pc = 10'd5;
    cyc();
    chk("t4_v5", 32'(ifc.out_valid), 32'd0);
    chk("t4_a5", 32'(ifc.inst_addr), 32'd5);
    ifc.redirect_pc = 10'd9;
    cyc();
    chk("t4_v9", 32'(ifc.out_valid), 32'd0);
    chk("t4_a9", 32'(ifc.inst_addr), 32'd9);
    ifc.redirect_pc = 10'd20;
    cyc();
    chk("t4_v20", 32'(ifc.out_valid), 32'd0);
    chk("t4_a20", 32'(ifc.inst_addr), 32'd20);
    ifc.redirect = 1'b0;
    push_exp(20); push_exp(21);
    cyc(); expect_out("t4_20");
    cyc(); expect_out("t4_21");

    // 5: PC wraps from 1023 to 0
    ifc.redirect = 1'b1; ifc.redirect_pc = 10'd1022;
    cyc();
    chk("t5_v", 32'(ifc.out_valid), 32'd0);
    chk("t5_a", 32'(ifc.inst_addr), 32'd1022);
    ifc.redirect = 1'b0;
    push_exp(1022); push_exp(1023); push_exp(0); push_exp(1);
    cyc(); expect_out("t5_1022");
    cyc(); expect_out("t5_1023");
    cyc(); expect_out("t5_0");
    cyc(); expect_out("t5_1");

    // 6: reset and redirect together on a full FIFO; reset wins
    ifc.out_ready = 1'b0;
    repeat (3) cyc();
    chk("t6_full_valid", 32'(ifc.out_valid), 32'd1);
    rst = 1'b1; ifc.redirect = 1'b1; ifc.redirect_pc = 10'd33;
    cyc();
    chk("t6_valid", 32'(ifc.out_valid), 32'd0);
    chk("t6_addr",  32'(ifc.inst_addr), 32'd0);
    rst = 1'b0; ifc.redirect = 1'b0; ifc.out_ready = 1'b1;
    push_exp(0); push_exp(1);
    cyc(); expect_out("t6_0");
    cyc(); expect_out("t6_1");

    chk("sb_empty", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
